// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a servo PWM pulse and turns it
// back into an integer angle: w = MIN_CYCLES + CYCLES_PER_DEG*N decodes to N.
// Also flags rejected pulses (too short, too long, overrun) and loss of signal.
//
// Build option: define SERVO_DEC_GLITCH_FILTER_EN to insert a FILTER_LEN-sample
// glitch filter after the input synchronizer. Without it the raw synchronizer
// output is used and every glitch counts as an edge.
module servo_pwm_decoder #(
  parameter int unsigned MIN_CYCLES     = 25000,
  parameter int unsigned CYCLES_PER_DEG = 138,
  parameter int unsigned MAX_ANGLE      = 180,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [31:0] angle,
  output logic        angle_valid,
  output logic [31:0] width,
  output logic        pulse_err,
  output logic        signal_lost
);

  localparam logic [31:0] MIN_C = 32'(MIN_CYCLES);
  localparam logic [31:0] CPD   = 32'(CYCLES_PER_DEG);
  localparam logic [31:0] MAX_C = 32'(MIN_CYCLES + MAX_ANGLE * CYCLES_PER_DEG);
  localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

  // Degenerate configurations would divide by zero or never let s move.
  if (CYCLES_PER_DEG == 0 || FILTER_LEN == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("servo_pwm_decoder: CYCLES_PER_DEG, FILTER_LEN and TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_TOOLONG,
    ST_DIVIDE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic sync_q1, sync_q2;
  logic s, s_d;
  logic rise;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [FW-1:0] flt_cnt;

  // s follows the synchronizer only after FILTER_LEN consecutive samples at the
  // new level; both edges slip by the same amount so the high time is preserved.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flt_cnt <= '0;
      s       <= 1'b0;
    end else if (sync_q2 != s) begin
      if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        s       <= sync_q2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end else begin
      flt_cnt <= '0;
    end
  end
`else
  assign s = sync_q2;
`endif

  // One-cycle delayed copy of s for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise = s & ~s_d;

  // ---------------------------------------------------------------------------
  // Measurement / division FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] rem, rem_n;
  logic [31:0] q, q_n;
  logic [31:0] shadow, shadow_n;
  logic [31:0] angle_n, width_n;
  logic        valid_n, err_n;

  // State and datapath registers; strobes are registered so they last one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      shadow      <= '0;
      angle       <= '0;
      width       <= '0;
      angle_valid <= 1'b0;
      pulse_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rem         <= rem_n;
      q           <= q_n;
      shadow      <= shadow_n;
      angle       <= angle_n;
      width       <= width_n;
      angle_valid <= valid_n;
      pulse_err   <= err_n;
    end
  end

  // Next-state: count high cycles, range check, then restoring division.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    q_n      = q;
    shadow_n = shadow;
    angle_n  = angle;
    width_n  = width;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          cnt_n   = 32'd1;
          state_n = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (s) begin
          // One more high cycle would push past MAX_CYCLES.
          if (cnt >= MAX_C) state_n = ST_TOOLONG;
          else              cnt_n   = cnt + 32'd1;
        end else if (cnt < MIN_C) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          rem_n    = cnt - MIN_C;
          q_n      = '0;
          shadow_n = cnt;
          state_n  = ST_DIVIDE;
        end
      end
      ST_TOOLONG: begin
        if (!s) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        // A new pulse arriving mid-division is dropped; the division finishes.
        if (rise) err_n = 1'b1;
        if (rem >= CPD) begin
          rem_n = rem - CPD;
          q_n   = q + 32'd1;
        end else begin
          angle_n = q;
          width_n = shadow;
          valid_n = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loss-of-signal watchdog
  // ---------------------------------------------------------------------------
  logic [31:0] tcnt;

  // Counter starts saturated so the block reports loss until the first pulse
  // decodes; a good decode clears the flag, reaching the limit sets it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt        <= TMO;
      signal_lost <= 1'b1;
    end else begin
      if (rise)            tcnt <= '0;
      else if (tcnt < TMO) tcnt <= tcnt + 32'd1;

      if (valid_n)                              signal_lost <= 1'b0;
      else if (!rise && tcnt == TMO - 32'd1)    signal_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder with scaled-down timing parameters:
// MIN=100, CPD=4, MAX_ANGLE=20 (MAX_CYCLES=180), TIMEOUT=2000, FILTER_LEN=4.
module tb_servo_pwm_decoder;

  localparam int unsigned MIN = 100;
  localparam int unsigned CPD = 4;
  localparam int unsigned MAXA = 20;
  localparam int unsigned TMO = 2000;
  localparam int unsigned FL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [31:0] angle;
  logic        angle_valid;
  logic [31:0] width;
  logic        pulse_err;
  logic        signal_lost;

  always #5 clock = ~clock;

  servo_pwm_decoder #(
    .MIN_CYCLES(MIN), .CYCLES_PER_DEG(CPD), .MAX_ANGLE(MAXA),
    .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)
  ) dut (
    .clock(clock), .reset(reset), .pwm_in(pwm_in),
    .angle(angle), .angle_valid(angle_valid), .width(width),
    .pulse_err(pulse_err), .signal_lost(signal_lost)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] ang;
    logic [31:0] wid;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_ok(input logic [31:0] w, input logic [31:0] a);
    exp_t e;
    e.is_err = 1'b0; e.ang = a; e.wid = w;
    expq.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1; e.ang = '0; e.wid = '0;
    expq.push_back(e);
  endtask

  // hi cycles high then lo cycles low, as seen by the synchronizer.
  task automatic pulse(input int hi, input int lo);
    @(negedge clock); pwm_in = 1'b1;
    repeat (hi) @(negedge clock);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_angle"}, angle, 32'd0);
    chk({tag, "_width"}, width, 32'd0);
    chk({tag, "_angle_valid"}, {31'd0, angle_valid}, 32'd0);
    chk({tag, "_pulse_err"}, {31'd0, pulse_err}, 32'd0);
    chk({tag, "_signal_lost"}, {31'd0, signal_lost}, 32'd1);
  endtask

  // Monitor: every strobe pops one expected event.
  always @(negedge clock) begin
    exp_t e;
    if (pulse_err) begin
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_pulse_err: got strobe expected none");
      end else begin
        e = expq.pop_front();
        chk("event_is_err", {31'd0, e.is_err}, 32'd1);
      end
    end
    if (angle_valid) begin
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_angle_valid: got angle %0d width %0d expected none", angle, width);
      end else begin
        e = expq.pop_front();
        chk("event_is_valid", {31'd0, e.is_err}, 32'd0);
        chk("angle", angle, e.ang);
        chk("width", width, e.wid);
        chk("lost_clears_with_valid", {31'd0, signal_lost}, 32'd0);
      end
    end
  end

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Nominal mid-range pulse: (140-100)/4 = 10
    exp_ok(140, 10); pulse(140, 200);
    chk("lost_after_first", {31'd0, signal_lost}, 32'd0);
    chk("hold_angle_10", angle, 32'd10);
    chk("hold_width_140", width, 32'd140);

    // Boundaries and truncation
    exp_ok(100, 0);  pulse(100, 200);
    exp_ok(180, 20); pulse(180, 200);
    exp_ok(123, 5);  pulse(123, 200);   // 100 + 4*5 + 3

    // Rejects: one short, one one-past-max; outputs untouched
    exp_err(); pulse(99, 200);
    exp_err(); pulse(181, 200);
    chk("reject_keeps_angle", angle, 32'd5);
    chk("reject_keeps_width", width, 32'd123);

    // 160-cycle pulse with a 2-cycle low glitch after 50 high cycles
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    exp_ok(160, 15);
`else
    exp_err();       // first piece, 50 cycles
    exp_ok(108, 2);  // second piece, (108-100)/4 = 2
`endif
    @(negedge clock); pwm_in = 1'b1;
    repeat (50) @(negedge clock); pwm_in = 1'b0;
    repeat (2) @(negedge clock);  pwm_in = 1'b1;
    repeat (108) @(negedge clock); pwm_in = 1'b0;
    repeat (200) @(negedge clock);

    // Overrun: new rise 5 cycles after a 180-cycle pulse, during the division
    exp_err(); exp_ok(180, 20);
    @(negedge clock); pwm_in = 1'b1;
    repeat (180) @(negedge clock); pwm_in = 1'b0;
    repeat (5) @(negedge clock);   pwm_in = 1'b1;
    repeat (150) @(negedge clock); pwm_in = 1'b0;
    repeat (200) @(negedge clock);
    chk("overrun_angle", angle, 32'd20);
    chk("lost_before_timeout", {31'd0, signal_lost}, 32'd0);

    // Silence past the timeout
    repeat (2100) @(negedge clock);
    chk("lost_after_timeout", {31'd0, signal_lost}, 32'd1);
    chk("timeout_keeps_angle", angle, 32'd20);
    chk("timeout_keeps_width", width, 32'd180);

    // Reset during the division of a 180-cycle pulse
    @(negedge clock); pwm_in = 1'b1;
    repeat (180) @(negedge clock); pwm_in = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("mid_divide_reset");
    reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("no_strobe_after_reset", expq.size(), 32'd0);
    exp_ok(140, 10); pulse(140, 200);
    chk("post_reset_angle", angle, 32'd10);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 500 && expq.size() != 0; i++) @(negedge clock);
    chk("queue_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Measures the high time of an incoming servo-style PWM pulse train and converts it back into an integer angle in degrees. It is the inverse of the servo PWM generator: a pulse of `MIN_CYCLES + CYCLES_PER_DEG*N` high cycles decodes to `N`. It sits between an external PWM input pin (RC receiver or loopback of our own servo output) and the processor register file, which reads `angle`. It also reports out-of-range pulses, overrun and loss of signal.

## Interface
Parameters:
- `MIN_CYCLES`, 25000 — high time (cycles) for 0°.
- `CYCLES_PER_DEG`, 138 — high cycles per degree.
- `MAX_ANGLE`, 180 — largest legal angle; `MAX_CYCLES = MIN_CYCLES + MAX_ANGLE*CYCLES_PER_DEG` (49840).
- `TIMEOUT_CYCLES`, 2000000 — rising-edge silence before `signal_lost`.
- `FILTER_LEN`, 4 — consecutive samples required by the glitch filter.

Ports:
- `clock` in 1 — sole clock; all logic on rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `pwm_in` in 1 — asynchronous PWM input.
- `angle` out 32 — last decoded angle, 0..MAX_ANGLE.
- `angle_valid` out 1 — one-cycle strobe when `angle` updates.
- `width` out 32 — high-time count of the last accepted pulse.
- `pulse_err` out 1 — one-cycle strobe on rejected pulse.
- `signal_lost` out 1 — level; no rising edge for `TIMEOUT_CYCLES`.

## Operation
- Input conditioning: `pwm_in` passes through a 2-flop synchronizer, then an optional filter (see Configuration). This gives level `s`. Edge detect uses a 1-cycle delayed copy of `s`.
- States:
  - IDLE: wait for a rising edge of `s`. On the edge, `cnt<=1` and go to HIGH.
  - HIGH: `cnt` increments each cycle while `s`=1.
    - If `cnt` would exceed `MAX_CYCLES`, go to TOOLONG.
    - On a falling edge with `cnt < MIN_CYCLES`: pulse `pulse_err` and return to IDLE.
    - Otherwise load `rem<=cnt-MIN_CYCLES` and `q<=0`, latch `cnt` into a width shadow, and go to DIVIDE.
  - TOOLONG: wait for `s`=0. Then pulse `pulse_err` and go to IDLE.
  - DIVIDE: restoring subtraction, one step per cycle.
    - If `rem >= CYCLES_PER_DEG`: `rem -= CYCLES_PER_DEG`, `q++`.
    - Else: `angle<=q`, `width<=` shadow, pulse `angle_valid`, go to IDLE.
- Result: `angle = floor((w-MIN_CYCLES)/CYCLES_PER_DEG)`, where w is the count of cycles with `s`=1. All arithmetic is 32-bit unsigned. Because w ≤ MAX_CYCLES, q ≤ MAX_ANGLE.
- Overrun: a rising edge of `s` seen in DIVIDE drops that new pulse and pulses `pulse_err` in the same cycle. The division completes normally.
- Timeout: a 32-bit counter clears on every rising edge of `s` and saturates at `TIMEOUT_CYCLES`. At saturation, `signal_lost`=1. `signal_lost` clears in the cycle `angle_valid` asserts. `angle` holds its value through signal loss.
- Rejected pulses never modify `angle` or `width`.

## Timing
- Reset values: `angle`=0, `width`=0, `angle_valid`=0, `pulse_err`=0, `signal_lost`=1, state IDLE, synchronizer flops 0.
- Reset asserted mid-pulse or mid-divide aborts immediately; no strobe is produced.
- Pipeline: `pwm_in` to `s` is 2 cycles (without the filter).
- Latency: `angle_valid` asserts q+2 cycles after the cycle in which `s` falls.
  - Worst case (180°): 182 cycles, well under the minimum low time at 50 Hz.
- `angle_valid` and `pulse_err` are never asserted in the same cycle except on overrun.
- Boundaries:
  - w = MIN_CYCLES is accepted (0°).
  - w = MAX_CYCLES is accepted (MAX_ANGLE).
  - w = MAX_CYCLES+1 is rejected.

## Configuration
- `SERVO_DEC_GLITCH_FILTER_EN` defined:
  - `s` changes only after `FILTER_LEN` consecutive synchronized samples at the new level.
  - Both edges are delayed by `FILTER_LEN` cycles, so w is unchanged.
  - Glitches shorter than `FILTER_LEN` cycles are invisible.
- Not defined: `s` is the raw synchronizer output, and every glitch is treated as an edge.

## Test plan
- 37420-cycle high pulse (90°), 1 ms low → `angle`=90, `width`=37420, one `angle_valid`, `pulse_err` never set.
- 25000-cycle pulse → `angle`=0; 49840-cycle pulse → `angle`=180; 25000+138*45+137 → `angle`=45 (truncation).
- 24999-cycle pulse, then 49841-cycle pulse → two `pulse_err` strobes, `angle` and `width` unchanged from the prior value.
- Out of reset: `signal_lost`=1. Send a valid pulse → `signal_lost` falls with `angle_valid`. Hold `pwm_in` low for 2000000 cycles → `signal_lost`=1, `angle` retained.
- 37420-cycle pulse containing a 2-cycle low glitch:
  - With `SERVO_DEC_GLITCH_FILTER_EN` → `angle`=90.
  - Without it → split pulses rejected or decoded short, no 90° result.
- Assert `reset` during DIVIDE of a 180° pulse → no strobe; outputs at reset values; the next valid pulse decodes correctly.
